// File: rtl/decode_queue.sv
// decode_queue: decodes RV32I/RV64I instructions from IF and buffers them in a circular queue for EX.
// Parameters: DATA_LEN (32 or 64) datapath width; QDEPTH (power of 2, 2..8) decoded-entry slots.
// Ports: clk, rst_n (synchronous, active-low);
//   IF side: in_valid, in_ready, in_inst, in_pc, flush;
//   register file: rs1, rs2, rs1_valid, rs2_valid, src1, src2, src_block;
//   EX side: out_valid, out_ready, out_pc, out_op1, out_op2, out_imm, out_alu_op, out_word,
//   out_rd, out_dest_wen, out_illegal.
// Macro DECODE_QUEUE_ILLEGAL_CHECK_EN: when defined, unrecognised encodings raise out_illegal.
module decode_queue #(
    parameter int DATA_LEN = 32,
    parameter int QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [DATA_LEN-1:0] in_pc,
    input  logic                flush,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                rs1_valid,
    output logic                rs2_valid,
    input  logic [DATA_LEN-1:0] src1,
    input  logic [DATA_LEN-1:0] src2,
    input  logic                src_block,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_pc,
    output logic [DATA_LEN-1:0] out_op1,
    output logic [DATA_LEN-1:0] out_op2,
    output logic [DATA_LEN-1:0] out_imm,
    output logic [3:0]          out_alu_op,
    output logic                out_word,
    output logic [4:0]          out_rd,
    output logic                out_dest_wen,
    output logic                out_illegal
);
    localparam int PW = $clog2(QDEPTH);
    localparam bit IS64 = (DATA_LEN == 64);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_MISC = 7'b0001111, OP_SYS = 7'b1110011, OP_IMM32 = 7'b0011011,
                           OP_REG32 = 7'b0111011;
    localparam logic [DATA_LEN-1:0] FOUR = DATA_LEN'(4);

    typedef struct packed {
        logic [DATA_LEN-1:0] pc, op1, op2, imm;
        logic [3:0]          alu_op;
        logic                word, dest_wen, illegal;
        logic [4:0]          rd;
    } ent_t;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    ent_t          slot_q [QDEPTH];
    ent_t          ent_d, head;
    logic          full, empty, push, pop;
    logic [6:0]    opc, f7;
    logic [2:0]    f3;
    logic [DATA_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, imm, op1, op2;
    logic [3:0]    alu, alu_rr;
    logic          bad, no_wb, word, r1v, r2v, rr_ok, sh_ok, shw_ok, ill;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];

    assign imm_i = DATA_LEN'($signed(in_inst[31:20]));
    assign imm_s = DATA_LEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = DATA_LEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = DATA_LEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = DATA_LEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    // inst[25] is a shamt bit only for RV64 non-W immediate shifts
    assign shamt = DATA_LEN'({in_inst[25] & IS64 & (opc == OP_IMM), in_inst[24:20]});

    assign rr_ok  = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
    assign shw_ok = (f7 == 7'b0) || (f7 == 7'b0100000 && f3 == 3'd5);
    assign sh_ok  = IS64 ? (in_inst[31:26] == 6'b0 || (in_inst[31:26] == 6'b010000 && f3 == 3'd5)) : shw_ok;

    always_comb begin
        case (f3)
            3'd0:    alu_rr = (in_inst[30] && (opc == OP_REG || opc == OP_REG32)) ? 4'd1 : 4'd0;
            3'd1:    alu_rr = 4'd2;
            3'd2:    alu_rr = 4'd3;
            3'd3:    alu_rr = 4'd4;
            3'd4:    alu_rr = 4'd5;
            3'd5:    alu_rr = in_inst[30] ? 4'd7 : 4'd6;
            3'd6:    alu_rr = 4'd8;
            default: alu_rr = 4'd9;
        endcase
    end

    always_comb begin
        imm = imm_i;
        op1 = src1;
        op2 = imm_i;
        alu = 4'd0;
        bad = 1'b0;
        no_wb = 1'b0;
        word = 1'b0;
        r1v = 1'b0;
        r2v = 1'b0;
        case (opc)
            OP_LUI:    begin imm = imm_u; op1 = '0; op2 = imm_u; end
            OP_AUIPC:  begin imm = imm_u; op1 = in_pc; op2 = imm_u; end
            OP_JAL:    begin imm = imm_j; op1 = in_pc; op2 = FOUR; end
            OP_JALR:   begin r1v = 1'b1; op1 = in_pc; op2 = FOUR; bad = f3 != 3'd0; end
            OP_BRANCH: begin
                imm = imm_b; op2 = src2; alu = 4'd1; r1v = 1'b1; r2v = 1'b1; no_wb = 1'b1;
                bad = f3[2:1] == 2'b01;
            end
            OP_LOAD:   begin r1v = 1'b1; bad = f3 == 3'd7 || (!IS64 && (f3 == 3'd3 || f3 == 3'd6)); end
            OP_STORE:  begin
                imm = imm_s; op2 = imm_s; r1v = 1'b1; r2v = 1'b1; no_wb = 1'b1;
                bad = f3[2] || (!IS64 && f3 == 3'd3);
            end
            OP_IMM:    begin
                r1v = 1'b1; alu = alu_rr;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    imm = shamt; op2 = shamt; bad = !sh_ok;
                end
            end
            OP_REG:    begin r1v = 1'b1; r2v = 1'b1; op2 = src2; alu = alu_rr; bad = !rr_ok; end
            OP_IMM32:  begin
                r1v = IS64; word = IS64; alu = alu_rr;
                if (f3[0]) begin imm = shamt; op2 = shamt; end
                bad = !IS64 || !(f3 == 3'd0 || ((f3 == 3'd1 || f3 == 3'd5) && shw_ok));
            end
            OP_REG32:  begin
                r1v = IS64; r2v = IS64; word = IS64; op2 = src2; alu = alu_rr;
                bad = !IS64 || !((f3 == 3'd0 && rr_ok) || ((f3 == 3'd1 || f3 == 3'd5) && shw_ok));
            end
            OP_MISC, OP_SYS: no_wb = 1'b1;
            default:   bad = 1'b1;
        endcase
        // unrecognised encodings fall back to a non-writing ADD
        if (bad) alu = 4'd0;
    end

`ifdef DECODE_QUEUE_ILLEGAL_CHECK_EN
    assign ill = bad;
`else
    assign ill = 1'b0;
`endif

    assign rs1_valid = r1v;
    assign rs2_valid = r2v;

    always_comb begin
        ent_d.pc       = in_pc;
        ent_d.op1      = op1;
        ent_d.op2      = op2;
        ent_d.imm      = imm;
        ent_d.alu_op   = alu;
        ent_d.word     = word;
        ent_d.rd       = in_inst[11:7];
        ent_d.dest_wen = !no_wb && !bad && in_inst[11:7] != 5'd0;
        ent_d.illegal  = ill;
    end

    assign full      = cnt_q == (PW+1)'(QDEPTH);
    assign empty     = cnt_q == '0;
    assign in_ready  = rst_n && !full && !src_block && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wptr_d = flush ? '0 : wptr_q + PW'(push);
        rptr_d = flush ? '0 : rptr_q + PW'(pop);
        cnt_d  = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot_q[wptr_q] <= ent_d;
    end

    assign head         = slot_q[rptr_q];
    assign out_pc       = head.pc;
    assign out_op1      = head.op1;
    assign out_op2      = head.op2;
    assign out_imm      = head.imm;
    assign out_alu_op   = head.alu_op;
    assign out_word     = head.word;
    assign out_rd       = head.rd;
    assign out_dest_wen = head.dest_wen;
    assign out_illegal  = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode_queue with 32-bit and 64-bit instances sharing stimulus.
module tb_decode_queue;
`ifdef DECODE_QUEUE_ILLEGAL_CHECK_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, src_block, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, src1, src2;
    logic        a_in_ready, a_rs1_valid, a_rs2_valid, a_out_valid, a_out_word, a_out_dest_wen, a_out_illegal;
    logic [4:0]  a_rs1, a_rs2, a_out_rd;
    logic [31:0] a_out_pc, a_out_op1, a_out_op2, a_out_imm;
    logic [3:0]  a_out_alu_op;
    logic        b_in_ready, b_rs1_valid, b_rs2_valid, b_out_valid, b_out_word, b_out_dest_wen, b_out_illegal;
    logic [4:0]  b_rs1, b_rs2, b_out_rd;
    logic [63:0] b_out_pc, b_out_op1, b_out_op2, b_out_imm;
    logic [3:0]  b_out_alu_op;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    decode_queue #(.DATA_LEN(32), .QDEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
        .in_pc(in_pc[31:0]), .flush(flush), .rs1(a_rs1), .rs2(a_rs2), .rs1_valid(a_rs1_valid),
        .rs2_valid(a_rs2_valid), .src1(src1[31:0]), .src2(src2[31:0]), .src_block(src_block),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_op1(a_out_op1),
        .out_op2(a_out_op2), .out_imm(a_out_imm), .out_alu_op(a_out_alu_op), .out_word(a_out_word),
        .out_rd(a_out_rd), .out_dest_wen(a_out_dest_wen), .out_illegal(a_out_illegal)
    );

    decode_queue #(.DATA_LEN(64), .QDEPTH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .rs1(b_rs1), .rs2(b_rs2), .rs1_valid(b_rs1_valid),
        .rs2_valid(b_rs2_valid), .src1(src1), .src2(src2), .src_block(src_block),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_op1(b_out_op1),
        .out_op2(b_out_op2), .out_imm(b_out_imm), .out_alu_op(b_out_alu_op), .out_word(b_out_word),
        .out_rd(b_out_rd), .out_dest_wen(b_out_dest_wen), .out_illegal(b_out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // push one instruction into an empty queue, check the head, then pop it
    // ck[0]: check operands, ck[1]: check immediate; w selects the 64-bit instance
    task automatic run_vec(input string tag, input logic [31:0] inst, input bit w, input bit [1:0] ck,
                           input logic [63:0] e_op1, input logic [63:0] e_op2, input logic [63:0] e_imm,
                           input logic [3:0] e_alu, input bit e_wen, input bit e_ill, input bit e_word);
        in_inst = inst;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"}, w ? b_out_valid : a_out_valid, 1'b1);
        if (ck[0]) begin
            check({tag, ".op1"}, w ? b_out_op1 : {32'b0, a_out_op1}, e_op1);
            check({tag, ".op2"}, w ? b_out_op2 : {32'b0, a_out_op2}, e_op2);
        end
        if (ck[1]) check({tag, ".imm"}, w ? b_out_imm : {32'b0, a_out_imm}, e_imm);
        check({tag, ".alu"}, w ? b_out_alu_op : a_out_alu_op, e_alu);
        check({tag, ".wen"}, w ? b_out_dest_wen : a_out_dest_wen, e_wen);
        check({tag, ".ill"}, w ? b_out_illegal : a_out_illegal, e_ill);
        check({tag, ".word"}, w ? b_out_word : a_out_word, e_word);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; src_block = 1'b0; out_ready = 1'b0;
        in_inst = 32'h00100093; in_pc = 64'h100; src1 = '0; src2 = '0;
        #1;
        check("rst_ready0", a_in_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready", a_in_ready, 1'b0);
            check("rst_valid", a_out_valid, 1'b0);
            check("rst_valid64", b_out_valid, 1'b0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("idle_valid", a_out_valid, 1'b0);
        in_valid = 1'b1;
        #1;
        check("first_ready", a_in_ready, 1'b1);
        check("no_bypass", a_out_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        check("first_valid", a_out_valid, 1'b1);
        check("first_op1", a_out_op1, 32'd0);
        check("first_op2", a_out_op2, 32'd1);
        check("first_alu", a_out_alu_op, 4'd0);
        check("first_rd", a_out_rd, 5'd1);
        check("first_wen", a_out_dest_wen, 1'b1);
        check("first_pc", a_out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("first_pop", a_out_valid, 1'b0);

        for (int k = 1; k <= 3; k++) begin
            in_inst = 32'h00000093 | (32'(k) << 20);
            in_valid = 1'b1;
            #1;
            check("fill_ready", a_in_ready, k < 3);
            tick();
        end
        in_valid = 1'b0;
        check("fill_head", a_out_op2, 32'd1);
        out_ready = 1'b1;
        tick();
        check("drain_head", a_out_op2, 32'd2);
        tick();
        check("drain_empty", a_out_valid, 1'b0);

        for (int k = 10; k <= 13; k++) begin
            in_inst = 32'h00000093 | (32'(k) << 20);
            in_valid = 1'b1;
            tick();
            check("wrap_valid", a_out_valid, 1'b1);
            check("wrap_head", a_out_op2, 32'(k));
        end
        in_valid = 1'b0;
        tick();
        check("pushpop_cnt1", a_out_valid, 1'b0);

        out_ready = 1'b0;
        for (int k = 20; k <= 21; k++) begin
            in_inst = 32'h00000093 | (32'(k) << 20);
            in_valid = 1'b1;
            tick();
        end
        check("full_ready", a_in_ready, 1'b0);
        in_inst = 32'h01600093;
        flush = 1'b1;
        #1;
        check("flush_ready", a_in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", a_out_valid, 1'b0);
        check("flush_valid64", b_out_valid, 1'b0);
        tick();
        check("flush_hold", a_out_valid, 1'b0);

        in_inst = 32'h002081B3; src1 = 64'h11; src2 = 64'h66; in_valid = 1'b1; src_block = 1'b1;
        #1;
        check("haz_ready", a_in_ready, 1'b0);
        check("haz_rs1", a_rs1, 5'd1);
        check("haz_rs2", a_rs2, 5'd2);
        check("haz_rs1v", a_rs1_valid, 1'b1);
        check("haz_rs2v", a_rs2_valid, 1'b1);
        tick();
        check("haz_hold", a_out_valid, 1'b0);
        src_block = 1'b0; src1 = 64'h55;
        #1;
        check("haz_release", a_in_ready, 1'b1);
        tick();
        in_valid = 1'b0; src1 = 64'h99;
        check("haz_op1", a_out_op1, 32'h55);
        check("haz_op2", a_out_op2, 32'h66);
        check("haz_rd", a_out_rd, 5'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        src1 = 64'h1000; src2 = 64'h2000; in_pc = 64'h400;
        run_vec("lui",    32'h123452B7, 0, 2'b11, 0,      32'h12345000, 32'h12345000, 4'd0, 1, 0, 0);
        run_vec("auipc",  32'h00001297, 0, 2'b01, 32'h400, 32'h1000, 0, 4'd0, 1, 0, 0);
        run_vec("jal",    32'h008000EF, 0, 2'b11, 32'h400, 32'd4, 32'd8, 4'd0, 1, 0, 0);
        run_vec("beq",    32'hFE208EE3, 0, 2'b11, 32'h1000, 32'h2000, 32'hFFFFFFFC, 4'd1, 0, 0, 0);
        run_vec("sw",     32'h0020A423, 0, 2'b01, 32'h1000, 32'd8, 0, 4'd0, 0, 0, 0);
        run_vec("srai",   32'h4040D193, 0, 2'b01, 32'h1000, 32'd4, 0, 4'd7, 1, 0, 0);
        run_vec("slti",   32'hFFF0A193, 0, 2'b01, 32'h1000, 32'hFFFFFFFF, 0, 4'd3, 1, 0, 0);
        run_vec("sltu",   32'h0020B1B3, 0, 2'b01, 32'h1000, 32'h2000, 0, 4'd4, 1, 0, 0);
        run_vec("sub",    32'h402081B3, 0, 2'b01, 32'h1000, 32'h2000, 0, 4'd1, 1, 0, 0);
        run_vec("nop",    32'h00000013, 0, 2'b00, 0, 0, 0, 4'd0, 0, 0, 0);
        run_vec("ecall",  32'h00000073, 0, 2'b00, 0, 0, 0, 4'd0, 0, 0, 0);
        run_vec("illop",  32'h0000007F, 0, 2'b00, 0, 0, 0, 4'd0, 0, ILL, 0);
        run_vec("srai33", 32'h4210D193, 0, 2'b00, 0, 0, 0, 4'd0, 0, ILL, 0);
        run_vec("addiw",  32'h0010009B, 1, 2'b01, 64'h1000, 64'd1, 0, 4'd0, 1, 0, 1);
        run_vec("addi_m1", 32'hFFF00093, 1, 2'b11, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'd0, 1, 0, 0);
        run_vec("srai64", 32'h4210D193, 1, 2'b01, 64'h1000, 64'd33, 0, 4'd7, 1, 0, 0);
        run_vec("illop64", 32'h0000007F, 1, 2'b00, 0, 0, 0, 4'd0, 0, ILL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
